// File: rtl/dmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and encodings for the data-memory access controller
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int BUS_AW = 32;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter2 : two-requester round-robin arbiter, one-hot grant
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Port that won most recently; it yields on the next contested cycle.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == PORT_CPU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PORT_CPU;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_access_ctrl : zero-fill sweep then CPU/debug round-robin data-memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  localparam state_e RESET_STATE = CLEAR_EN ? ST_CLEAR : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q;
  logic              sweep_last;

  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              init_q;

  logic              rd_pend_q;
  logic              rd_port_q;
  logic              cpu_rv_q, dbg_rv_q;
  logic [DATA_W-1:0] cpu_rd_q, dbg_rd_q;

  logic [1:0]        grant;
  logic              arb_adv;

  // Upper address bits alias away by design.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

  assign sweep_last = (sweep_q == {ADDR_W{1'b1}});

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({dbg_req, cpu_req}),
    .advance (arb_adv),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_CLEAR) && sweep_last) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    en_d      = 1'b0;
    rw_d      = RW_READ;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_gnt_d = 1'b0;
    dbg_gnt_d = 1'b0;
    arb_adv   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        en_d    = 1'b1;
        rw_d    = RW_WRITE;
        addr_d  = sweep_q;
        wdata_d = '0;
      end
      default: begin
        arb_adv = 1'b1;
        if (grant[1]) begin
          en_d      = 1'b1;
          rw_d      = dbg_we;
          addr_d    = dbg_addr[ADDR_W-1:0];
          wdata_d   = dbg_wdata;
          dbg_gnt_d = 1'b1;
        end else if (grant[0]) begin
          en_d      = 1'b1;
          rw_d      = cpu_we;
          addr_d    = cpu_addr[ADDR_W-1:0];
          wdata_d   = cpu_wdata;
          cpu_gnt_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      rw_q      <= RW_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_gnt_q <= 1'b0;
      dbg_gnt_q <= 1'b0;
      sweep_q   <= '0;
      init_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_gnt_q <= cpu_gnt_d;
      dbg_gnt_q <= dbg_gnt_d;
      if (state_q == ST_CLEAR) begin
        sweep_q <= sweep_q + 1'b1;
      end
      if (state_q == ST_IDLE) begin
        init_q <= 1'b1;
      end
    end
  end

  // Read return: memory samples the access one edge after issue, data lands the edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_CPU;
      cpu_rv_q  <= 1'b0;
      dbg_rv_q  <= 1'b0;
      cpu_rd_q  <= '0;
      dbg_rd_q  <= '0;
    end else begin
      rd_pend_q <= en_q && (rw_q == RW_READ);
      rd_port_q <= dbg_gnt_q;
      cpu_rv_q  <= rd_pend_q && (rd_port_q == PORT_CPU);
      dbg_rv_q  <= rd_pend_q && (rd_port_q == PORT_DBG);
      if (rd_pend_q && (rd_port_q == PORT_CPU)) begin
        cpu_rd_q <= mem_rdata;
      end
      if (rd_pend_q && (rd_port_q == PORT_DBG)) begin
        dbg_rd_q <= mem_rdata;
      end
    end
  end

  assign mem_en     = en_q;
  assign mem_rw     = rw_q;
  assign mem_addr   = BUS_AW'(addr_q);
  assign mem_wdata  = wdata_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_rvalid = cpu_rv_q;
  assign dbg_rvalid = dbg_rv_q;
  assign cpu_rdata  = cpu_rd_q;
  assign dbg_rdata  = dbg_rd_q;
  assign init_done  = init_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl : randomized transaction-level check of dmem_access_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 16-word memory with zero-fill sweep
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_rw, init_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_access_ctrl #(.ADDR_W(4), .DATA_W(32), .CLEAR_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Instance B: full 16-bit address space, no sweep
  logic        b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
  logic        b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid;
  logic [31:0] b_cpu_rdata, b_dbg_rdata;
  logic        b_mem_en, b_mem_rw, b_init_done;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'hCAFE_0007;

  dmem_access_ctrl #(.ADDR_W(16), .DATA_W(32), .CLEAR_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .init_done(b_init_done)
  );

  // Synchronous RAM behind instance A
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) ram[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[3:0]];
    end
  end

  // Reference model state
  typedef struct { bit port; logic [31:0] data; int due; } ret_t;
  ret_t        pend[$];
  bit          m_clear;
  int          m_sweep;
  bit          m_last;
  logic [31:0] m_mem [16];
  int          cyc;
  logic        e_en, e_rw, e_cg, e_dg, e_crv, e_drv, e_init;
  logic [31:0] e_addr, e_wd, e_crd, e_drd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_clear = 1'b1; m_sweep = 0; m_last = 1'b0;
    e_en = 0; e_rw = 0; e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0; e_init = 0;
    e_addr = 0; e_wd = 0; e_crd = 0; e_drd = 0;
  endtask

  task automatic check_all();
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_rw", 32'(mem_rw), 32'(e_rw));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dbg_rdata", dbg_rdata, e_drd);
    chk("init_done", 32'(init_done), 32'(e_init));
  endtask

  // One clock: predict what the edge does from the sampled requests, then compare.
  task automatic step();
    bit          win, we;
    logic [31:0] a, wd;
    ret_t        r;
    @(posedge clk);
    cyc++;
    e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0;
    e_init = e_init | !m_clear;
    if (m_clear) begin
      e_en = 1; e_rw = 1; e_addr = 32'(m_sweep); e_wd = 0;
      m_mem[m_sweep] = 0;
      if (m_sweep == 15) m_clear = 1'b0;
      m_sweep = (m_sweep + 1) % 16;
    end else if (cpu_req || dbg_req) begin
      win = (cpu_req && dbg_req) ? !m_last : dbg_req;
      m_last = win;
      a  = (win ? dbg_addr : cpu_addr) % 16;
      we = win ? dbg_we : cpu_we;
      wd = win ? dbg_wdata : cpu_wdata;
      e_en = 1; e_rw = we; e_addr = a; e_wd = wd;
      if (win) e_dg = 1; else e_cg = 1;
      if (we) m_mem[a] = wd;
      else pend.push_back('{win, m_mem[a], cyc + 2});
    end else begin
      e_en = 0; e_rw = 0;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.port) begin e_drv = 1; e_drd = r.data; end
      else        begin e_crv = 1; e_crd = r.data; end
    end
    @(negedge clk);
    check_all();
  endtask

  // Ports not yet granted keep their access; otherwise draw a new one.
  task automatic new_inputs(input int req_pct);
    if (!(cpu_req && !e_cg)) begin
      cpu_req = ($urandom_range(99) < req_pct); cpu_we = $urandom_range(1);
      cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (!(dbg_req && !e_dg)) begin
      dbg_req = ($urandom_range(99) < req_pct); dbg_we = $urandom_range(1);
      dbg_addr = $urandom; dbg_wdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ram[i] = $urandom; m_mem[i] = 'x; end
    cyc = 0;
    model_reset();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;
    repeat (3) @(negedge clk);
    check_all();

    // CPU load held through the sweep; instance B gets a load right away
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd3;
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'd7;
    rst = 1'b1;

    step();
    chk("b_init_done", 32'(b_init_done), 32'd1);
    chk("b_cpu_gnt_first", 32'(b_cpu_gnt), 32'd1);
    chk("b_mem_rw_first", 32'(b_mem_rw), 32'd0);
    chk("b_mem_addr_first", b_mem_addr, 32'd7);
    b_cpu_req = 0;
    b_dbg_req = 1; b_dbg_we = 1; b_dbg_addr = 32'h0001_0003; b_dbg_wdata = 32'h55;
    step();
    chk("b_dbg_gnt", 32'(b_dbg_gnt), 32'd1);
    chk("b_cpu_gnt_idle", 32'(b_cpu_gnt), 32'd0);
    chk("b_mem_addr_wrap", b_mem_addr, 32'h0000_0003);
    chk("b_mem_rw_wr", 32'(b_mem_rw), 32'd1);
    b_dbg_req = 0;
    step();
    chk("b_cpu_rvalid", 32'(b_cpu_rvalid), 32'd1);
    chk("b_cpu_rdata", b_cpu_rdata, 32'hCAFE_0007);
    chk("b_dbg_rvalid", 32'(b_dbg_rvalid), 32'd0);
    chk("b_mem_en_idle", 32'(b_mem_en), 32'd0);
    step();
    chk("b_cpu_rvalid_pulse", 32'(b_cpu_rvalid), 32'd0);

    // Rest of the sweep plus the first post-sweep grant
    repeat (13) step();
    chk("cpu_held_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 0;
    step(); step();

    // Store then load the same word
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd5; cpu_wdata = 32'hDEAD_BEEF;
    step();
    cpu_we = 0;
    step();
    cpu_req = 0;
    step(); step();
    chk("cpu_load_back", cpu_rdata, 32'hDEAD_BEEF);

    // Both ports requesting back-to-back
    cpu_req = 1; dbg_req = 1; cpu_we = 0; dbg_we = 0;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = $urandom; dbg_addr = $urandom;
      step();
    end
    cpu_req = 0; dbg_req = 0;
    step(); step();

    repeat (300) begin
      new_inputs(70);
      step();
    end

    // Reset during an in-flight read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd9; dbg_req = 0;
    step();
    cpu_req = 0;
    #2;
    do_reset();
    repeat (20) step();
    repeat (200) begin
      new_inputs(60);
      step();
    end
    cpu_req = 0; dbg_req = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
